// File: rtl/nes_pad_responder_if.sv
// Pad-side signal bundle for nes_pad_responder.
// The master side is the console/host plus button source; the slave side is
// the responder, which drives the serial data and the status outputs.
interface nes_pad_responder_if #(
  parameter int NUM_BITS = 8
) ();

  // Handshake semantics: there is no valid/ready pair. nes_latch is a level
  // strobe (high = capture buttons and restart the frame), nes_clk advances
  // one bit per rising edge, and nes_data is valid whenever the host samples
  // it after the responder's pin-to-data latency has elapsed.
  logic [NUM_BITS-1:0] buttons;
  logic                nes_latch;
  logic                nes_clk;
  logic                nes_data;
  logic                frame_done;
  logic [4:0]          shift_count;

  modport master (
    output buttons,
    output nes_latch,
    output nes_clk,
    input  nes_data,
    input  frame_done,
    input  shift_count
  );

  modport slave (
    input  buttons,
    input  nes_latch,
    input  nes_clk,
    output nes_data,
    output frame_done,
    output shift_count
  );

endinterface

// File: rtl/nes_pad_responder.sv
// Game-pad emulator: answers an NES/SNES-style host. A latch strobe captures
// the button vector, each host clock rising edge shifts out the next bit on
// an active-low serial line, and a one-cycle pulse marks the end of a frame.
// Host lines are asynchronous and are resynchronized before any use.
module nes_pad_responder #(
  parameter int NUM_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nes_pad_responder_if.slave   pad,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Value of shift_count at which the next shift completes the frame.
  localparam logic [4:0] LAST_SHIFT = 5'(NUM_BITS - 1);

  // Synchronizer chains; index 0 samples the pin.
  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] nclk_sync;
  logic                   nclk_hist;
  logic                   latch_s;
  logic                   nclk_s;
  logic                   nclk_rise;

  state_t                 state, state_n;
  logic [NUM_BITS-1:0]    shreg, shreg_n;
  logic [4:0]             count, count_n;
  logic                   done_n;
  logic                   data_q;
  logic                   done_q;

  // Bring the asynchronous host strobes into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync <= '0;
      nclk_sync  <= '0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], pad.nes_latch};
      nclk_sync  <= {nclk_sync[SYNC_STAGES-2:0], pad.nes_clk};
    end
  end

  assign latch_s = latch_sync[SYNC_STAGES-1];
  assign nclk_s  = nclk_sync[SYNC_STAGES-1];

  // History flop for edge detection; it only ever follows the synchronized
  // level, so a host clock held high across reset release produces at most
  // one edge, and that edge lands in IDLE where it is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nclk_hist <= 1'b0;
    end else begin
      nclk_hist <= nclk_s;
    end
  end

  assign nclk_rise = nclk_s & ~nclk_hist;

  // State, shift register, counter and done flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      count  <= count_n;
      done_q <= done_n;
    end
  end

  // Next-state logic: latch has priority over everything, including a
  // host clock edge arriving in the same cycle.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    count_n = count;
    done_n  = 1'b0;

    if (latch_s) begin
      state_n = ST_LOAD;
      shreg_n = pad.buttons;
      count_n = '0;
    end else begin
      case (state)
        ST_LOAD: begin
          // Keep the buttons captured in the last latched cycle.
          state_n = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (nclk_rise) begin
            shreg_n = {1'b0, shreg[NUM_BITS-1:1]};
            count_n = count + 5'd1;
            if (count == LAST_SHIFT) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Frame complete: extra host clocks are ignored until next latch.
          state_n = ST_DONE;
        end
        default: begin
          // IDLE: wait for the first latch; host clocks are ignored.
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Serial output flop: active-low copy of the current LSB while a frame is
  // being loaded or shifted, idle-high otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 1'b1;
    end else if (state == ST_LOAD || state == ST_SHIFT) begin
      data_q <= ~shreg[0];
    end else begin
      data_q <= 1'b1;
    end
  end

  assign pad.nes_data    = data_q;
  assign pad.frame_done  = done_q;
  assign pad.shift_count = count;
  assign dbg_state       = state;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Bench for nes_pad_responder: an 8-bit and a 16-bit responder share the
// host latch/clock lines; frames are driven from a vector table plus
// hand-written sequences for latency, abort, overrun and reset cases.
module tb_nes_pad_responder;

  localparam int HALF = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        latch;
  logic        nclk;
  logic [7:0]  buttons8;
  logic [15:0] buttons16;
  logic [1:0]  state8;
  logic [1:0]  state16;

  nes_pad_responder_if #(.NUM_BITS(8))  pad8();
  nes_pad_responder_if #(.NUM_BITS(16)) pad16();

  assign pad8.nes_latch  = latch;
  assign pad8.nes_clk    = nclk;
  assign pad8.buttons    = buttons8;
  assign pad16.nes_latch = latch;
  assign pad16.nes_clk   = nclk;
  assign pad16.buttons   = buttons16;

  nes_pad_responder #(.NUM_BITS(8), .SYNC_STAGES(2)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .pad       (pad8),
    .dbg_state (state8)
  );

  nes_pad_responder #(.NUM_BITS(16), .SYNC_STAGES(2)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .pad       (pad16),
    .dbg_state (state16)
  );

  // ---------------- scoreboard ----------------
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   done8_cnt    = 0;
  int   done16_cnt   = 0;
  logic exp_q[$];

  always @(posedge clk) begin
    if (pad8.frame_done)  done8_cnt  <= done8_cnt + 1;
    if (pad16.frame_done) done16_cnt <= done16_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_data(input bit sel);
    return sel ? pad16.nes_data : pad8.nes_data;
  endfunction

  function automatic logic [4:0] get_count(input bit sel);
    return sel ? pad16.shift_count : pad8.shift_count;
  endfunction

  function automatic int get_done(input bit sel);
    return sel ? done16_cnt : done8_cnt;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_pulse();
    nclk = 1'b1;
    tick(HALF);
    nclk = 1'b0;
    tick(HALF);
  endtask

  // One host frame: latch, optional button change after latch release,
  // then sample before each clock pulse and once after the last one.
  task automatic run_frame(input bit sel, input logic [15:0] btn,
                           input logic [15:0] btn_after, input int pulses,
                           input logic [31:0] exp_serial, input string tag,
                           output int done_delta);
    int   d0;
    logic e;
    d0 = get_done(sel);
    if (sel) buttons16 = btn; else buttons8 = btn[7:0];
    latch = 1'b1;
    tick(HALF);
    check({tag, " count_in_latch"}, 32'(get_count(sel)), 32'd0);
    latch = 1'b0;
    tick(HALF);
    if (sel) buttons16 = btn_after; else buttons8 = btn_after[7:0];
    for (int i = 0; i <= pulses; i++) exp_q.push_back(exp_serial[i]);
    for (int i = 0; i <= pulses; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s bit%0d", tag, i), 32'(get_data(sel)), 32'(e));
      if (pulses > 0 && i == pulses - 1)
        check({tag, " done_early"}, 32'(get_done(sel) - d0), 32'd0);
      if (i < pulses) clk_pulse();
    end
    done_delta = get_done(sel) - d0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  btn;
    int          pulses;
    logic [15:0] exp_serial;
    logic [4:0]  exp_count;
    int          exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          dd;
    int          d0;
    logic [7:0]  rb;

    rb = 8'($urandom_range(0, 255));
    vecs[0] = '{8'b1000_0101, 8, 16'hFF7A, 5'd8, 1};
    vecs[1] = '{8'hFF,        8, 16'hFF00, 5'd8, 1};
    vecs[2] = '{8'h00,        8, 16'hFFFF, 5'd8, 1};
    vecs[3] = '{8'h5A,        8, 16'hFFA5, 5'd8, 1};
    vecs[4] = '{8'h3C,        3, 16'hFFC3, 5'd3, 0};
    vecs[5] = '{8'h0F,        8, 16'hFFF0, 5'd8, 1};
    vecs[6] = '{rb,           8, {8'hFF, ~rb}, 5'd8, 1};

    // Reset state
    rst_n = 1'b0; latch = 1'b0; nclk = 1'b0;
    buttons8 = 8'h00; buttons16 = 16'h0000;
    tick(3);
    check("rst data8",   32'(pad8.nes_data), 32'd1);
    check("rst done8",   32'(pad8.frame_done), 32'd0);
    check("rst count8",  32'(pad8.shift_count), 32'd0);
    check("rst state8",  32'(state8), 32'd0);
    check("rst data16",  32'(pad16.nes_data), 32'd1);
    check("rst count16", 32'(pad16.shift_count), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Latch pin-to-data latency: 4 cycles with two sync stages
    buttons8 = 8'h01;
    latch = 1'b1;
    tick(3);
    check("latch_lat before", 32'(pad8.nes_data), 32'd1);
    tick(1);
    check("latch_lat at", 32'(pad8.nes_data), 32'd0);
    tick(HALF);
    latch = 1'b0;
    buttons8 = 8'h02;
    tick(HALF);
    // buttons8 changed only after the register was captured? No: it changed
    // at latch release, within the sync delay, so reload it cleanly.
    buttons8 = 8'h02;
    latch = 1'b1; tick(HALF); latch = 1'b0; tick(HALF);
    check("clk_lat start", 32'(pad8.nes_data), 32'd1);
    nclk = 1'b1;
    tick(3);
    check("clk_lat before", 32'(pad8.nes_data), 32'd1);
    tick(1);
    check("clk_lat at", 32'(pad8.nes_data), 32'd0);
    check("clk_lat count", 32'(pad8.shift_count), 32'd1);
    tick(HALF);
    nclk = 1'b0;
    tick(HALF);

    // Table-driven frames (row 4 aborted by row 5's latch)
    for (int r = 0; r < 7; r++) begin
      run_frame(1'b0, {8'h00, vecs[r].btn}, {8'h00, vecs[r].btn}, vecs[r].pulses,
                {16'h0000, vecs[r].exp_serial}, $sformatf("row%0d", r), dd);
      check($sformatf("row%0d count", r), 32'(pad8.shift_count), 32'(vecs[r].exp_count));
      check($sformatf("row%0d done", r), dd, vecs[r].exp_done);
      if (vecs[r].pulses == 8)
        check($sformatf("row%0d state", r), 32'(state8), 32'd3);
      if (r == 0) begin
        // Overrun: extra host clocks after the frame are ignored
        d0 = done8_cnt;
        for (int k = 0; k < 4; k++) clk_pulse();
        check("overrun data",  32'(pad8.nes_data), 32'd1);
        check("overrun count", 32'(pad8.shift_count), 32'd8);
        check("overrun done",  done8_cnt - d0, 32'd0);
      end
    end

    // Buttons change after latch: frame keeps captured value
    run_frame(1'b0, 16'h00FF, 16'h0000, 8, 32'h0000_FF00, "hold_ff", dd);
    check("hold_ff done", dd, 1);
    run_frame(1'b0, 16'h0000, 16'h0000, 8, 32'h0000_FFFF, "next_00", dd);
    check("next_00 done", dd, 1);

    // 16-bit pad
    run_frame(1'b1, 16'h8001, 16'h8001, 16, 32'h0001_7FFE, "snes", dd);
    check("snes count", 32'(pad16.shift_count), 32'd16);
    check("snes done", dd, 1);
    check("snes state", 32'(state16), 32'd3);

    // Reset mid-frame with host clock held high across release
    buttons8 = 8'h20;
    latch = 1'b1; tick(HALF); latch = 1'b0; tick(HALF);
    for (int k = 0; k < 5; k++) clk_pulse();
    check("prerst data",  32'(pad8.nes_data), 32'd0);
    check("prerst count", 32'(pad8.shift_count), 32'd5);
    d0 = done8_cnt;
    nclk = 1'b1;
    tick(HALF);
    rst_n = 1'b0;
    #1;
    check("rst_async data", 32'(pad8.nes_data), 32'd1);
    check("rst_async count", 32'(pad8.shift_count), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check("postrst data",  32'(pad8.nes_data), 32'd1);
    check("postrst count", 32'(pad8.shift_count), 32'd0);
    check("postrst state", 32'(state8), 32'd0);
    check("postrst done",  done8_cnt - d0, 32'd0);
    nclk = 1'b0;
    tick(HALF);
    run_frame(1'b0, 16'h0020, 16'h0020, 8, 32'h0000_FFDF, "clean", dd);
    check("clean done", dd, 1);
    check("clean count", 32'(pad8.shift_count), 32'd8);

    check("queue_empty", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
